// File: rtl/hazard_unit_v2.sv
// hazard_unit_v2: interlock controller beside ID (load-use, branch, MDU, backend freeze, watchdog).
// Optional perf counters compiled in with `define HAZ_PERF_EN.

// Per-source comparator: one instance per ID source operand.
module hazard_src_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              vld,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic [REG_AW-1:0] mem_wreg,
  output logic              hit_ex,
  output logic              hit_mem
);
  // r0 is hardwired zero, so a write to it never creates a dependency.
  assign hit_ex  = vld && (src == ex_wreg)  && (ex_wreg  != '0);
  assign hit_mem = vld && (src == mem_wreg) && (mem_wreg != '0);
endmodule

module hazard_unit_v2 #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int MDU_LAT    = 32,
  parameter int DELAY_SLOT = 0,
  parameter int WDOG_MAX   = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_vld,
  input  logic                      id_branch,
  input  logic                      id_taken,
  input  logic                      id_jump,
  input  logic                      id_jump_reg,
  input  logic                      id_mdu_start,
  input  logic                      id_hilo_read,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         ex_wreg,
  input  logic                      mem_memread,
  input  logic [REG_AW-1:0]         mem_wreg,
  input  logic                      ext_stall,
  output logic                      stall_if,
  output logic                      flush_if,
  output logic                      flush_id,
  output logic                      freeze,
  output logic                      mdu_busy,
  output logic [2:0]                stall_cause,
  output logic                      hang_err,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_flush_cnt
);
  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_LU   = 3'd1;
  localparam logic [2:0] CAUSE_BEX  = 3'd2;
  localparam logic [2:0] CAUSE_BMEM = 3'd3;
  localparam logic [2:0] CAUSE_MDU  = 3'd4;
  localparam logic [2:0] CAUSE_EXT  = 3'd5;

  localparam int MDU_W = $clog2(MDU_LAT + 1);
  localparam int WD_W  = (WDOG_MAX < 1) ? 1 : $clog2(WDOG_MAX + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_MAX);
  localparam bit WD_EN = (WDOG_MAX != 0);
  localparam bit DS_EN = (DELAY_SLOT != 0);

  logic [NUM_SRC-1:0] hit_ex, hit_mem;
  logic match_ex, match_mem, ctrl_reg;
  logic load_use, br_ex, br_mem, mdu_haz, data_haz;
  logic [MDU_W-1:0] mdu_cnt;
  logic [WD_W-1:0]  stall_run, stall_run_nxt;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hazard_src_match #(.REG_AW(REG_AW)) u_match (
      .src     (id_src[k*REG_AW +: REG_AW]),
      .vld     (id_src_vld[k]),
      .ex_wreg (ex_wreg),
      .mem_wreg(mem_wreg),
      .hit_ex  (hit_ex[k]),
      .hit_mem (hit_mem[k])
    );
  end

  assign match_ex  = |hit_ex;
  assign match_mem = |hit_mem;
  // Branches and jr/jalr resolve in ID, so they need the operand a stage early.
  assign ctrl_reg  = id_branch | id_jump_reg;

  assign load_use = ex_memread & match_ex;
  assign br_ex    = ctrl_reg & ex_regwrite & match_ex;
  assign br_mem   = ctrl_reg & mem_memread & match_mem;
  assign mdu_haz  = mdu_busy & (id_hilo_read | id_mdu_start);
  assign data_haz = load_use | br_ex | br_mem | mdu_haz;

  assign freeze   = ext_stall;
  assign stall_if = ext_stall | data_haz;
  assign flush_id = ~ext_stall & data_haz;
  assign flush_if = ~stall_if & ~DS_EN & ((id_branch & id_taken) | id_jump | id_jump_reg);

  always_comb begin
    stall_cause = CAUSE_NONE;
    if (ext_stall)     stall_cause = CAUSE_EXT;
    else if (load_use) stall_cause = CAUSE_LU;
    else if (br_ex)    stall_cause = CAUSE_BEX;
    else if (br_mem)   stall_cause = CAUSE_BMEM;
    else if (mdu_haz)  stall_cause = CAUSE_MDU;
  end

  // MDU keeps counting through freezes; a stalled start never reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          mdu_cnt <= '0;
    else if (id_mdu_start && !stall_if)  mdu_cnt <= MDU_W'(MDU_LAT);
    else if (mdu_cnt != '0)              mdu_cnt <= mdu_cnt - MDU_W'(1);
  end
  assign mdu_busy = (mdu_cnt != '0);

  always_comb begin
    stall_run_nxt = '0;
    if (stall_if) stall_run_nxt = (stall_run >= WD_LIM) ? WD_LIM : stall_run + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_run <= '0;
      hang_err  <= 1'b0;
    end else begin
      stall_run <= stall_run_nxt;
      if (WD_EN && stall_if && (stall_run_nxt == WD_LIM)) hang_err <= 1'b1;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + 32'(stall_if);
      perf_flush_q <= perf_flush_q + 32'(flush_if);
    end
  end
  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_cnt    = '0;
`endif

endmodule

// File: doc/hazard_unit_v2.md
Name: hazard_unit_v2

Overview:
Parametrised hazard/interlock controller for the 5-stage MIPS core. It supersedes the purely combinational load-use/branch hazard logic and adds:
- per-source valid masking;
- a configurable branch delay-slot mode;
- a multi-cycle MDU (mult/div) busy counter that interlocks HI/LO readers;
- an external backend freeze;
- a consecutive-stall watchdog.
It sits beside the ID stage and drives PC/IF-ID hold, IF flush and ID/EX bubble.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of source-register operands checked per ID instruction
MDU_LAT, 32, cycles from MDU start until HI/LO is valid (>=1)
DELAY_SLOT, 0, 1 = branch delay slot architected (never flush IF on control transfer)
WDOG_MAX, 1023, consecutive stall cycles that raise hang_err; 0 disables watchdog

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_src  in  NUM_SRC*REG_AW  ID source register numbers, src k at [k*REG_AW +: REG_AW]
id_src_vld  in  NUM_SRC  source k is actually read by the ID instruction
id_branch  in  1  ID holds conditional branch
id_taken  in  1  ID branch condition true
id_jump  in  1  ID holds j/jal
id_jump_reg  in  1  ID holds jr/jalr (reads register in ID)
id_mdu_start  in  1  ID holds mult/multu/div/divu
id_hilo_read  in  1  ID holds mfhi/mflo
ex_regwrite  in  1  EX instruction writes register file
ex_memread  in  1  EX instruction is a load
ex_wreg  in  REG_AW  EX destination register
mem_memread  in  1  MEM instruction is a load
mem_wreg  in  REG_AW  MEM destination register
ext_stall  in  1  backend (cache/bus) not ready
stall_if  out  1  hold PC and IF/ID register
flush_if  out  1  squash IF/ID register
flush_id  out  1  insert bubble into ID/EX
freeze  out  1  hold all pipeline registers (ID/EX, EX/MEM, MEM/WB)
mdu_busy  out  1  MDU result pending
stall_cause  out  3  0 none, 1 load-use, 2 branch-on-EX, 3 branch-on-MEM-load, 4 MDU, 5 ext
hang_err  out  1  sticky watchdog error
perf_stall_cycles  out  32  stall cycle counter (optional feature)
perf_flush_cnt  out  32  IF flush counter (optional feature)

Behaviour:
- Match for src k against register r: id_src_vld[k] & (src_k == r) & (r != 0). match(r) = OR over k.
- Hazard terms:
  - load_use = ex_memread & match(ex_wreg).
  - br_ex = (id_branch|id_jump_reg) & ex_regwrite & match(ex_wreg).
  - br_mem = (id_branch|id_jump_reg) & mem_memread & match(mem_wreg).
  - mdu_haz = mdu_busy & (id_hilo_read|id_mdu_start).
- Priority: ext > load_use > br_ex > br_mem > mdu_haz. stall_cause reflects the highest active term; otherwise 0.
- ext_stall=1: freeze=1, stall_if=1, flush_id=0, flush_if=0.
- ext_stall=0 with any data hazard: stall_if=1, flush_id=1, freeze=0, flush_if=0.
- No hazard: stall_if=0, flush_id=0, freeze=0.
- flush_if = ~stall_if & ~DELAY_SLOT & ((id_branch&id_taken) | id_jump | id_jump_reg). A stalled branch never flushes; the flush happens on the cycle it issues.
- All the above outputs are combinational, with zero latency.
- MDU counter, width clog2(MDU_LAT+1), reset 0:
  - loads MDU_LAT when id_mdu_start & ~stall_if;
  - otherwise decrements when nonzero, including during freeze (MDU runs free).
  - mdu_busy = (cnt != 0).
  - A second mdu_start while busy is stalled (mdu_haz), not restarted.
- Watchdog stall_run counter, reset 0:
  - increments, saturating, while stall_if=1; clears to 0 on a cycle with stall_if=0.
  - When it reaches WDOG_MAX (and WDOG_MAX != 0), hang_err sets and stays 1 until reset.
- Reset (async assert, sync-safe release): mdu cnt=0, stall_run=0, hang_err=0, perf counters=0. Combinational outputs follow inputs with mdu_busy=0. Reset mid-MDU-operation drops busy immediately.

Optional Feature:
HAZ_PERF_EN:
- Defined: perf_stall_cycles increments each cycle stall_if=1; perf_flush_cnt increments each cycle flush_if=1. Both are 32-bit, wrap at 2^32, reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
1. ex_memread=1, ex_wreg=8, id_src={rt=8, rs=3}, id_src_vld=2'b11 -> stall_if=1, flush_id=1, stall_cause=1. Same stimulus with id_src_vld=2'b01 (rt unused) -> stall_if=0.
2. id_branch=1, id_taken=1, ex_regwrite=1, ex_wreg=5, rs=5 -> stall 1 cycle, flush_if=0 (cause 2). Next cycle ex_wreg=0 -> stall_if=0, flush_if=1 (DELAY_SLOT=0). Rerun with DELAY_SLOT=1 -> flush_if stays 0.
3. MDU_LAT=4: id_mdu_start for 1 cycle, then id_hilo_read held -> mdu_busy=1 for exactly 4 cycles, stall_if=1 with cause 4 for those 4 cycles, released on cycle 5.
4. ext_stall=1 together with load_use -> freeze=1, stall_if=1, flush_id=0, cause=5. MDU counter still decrements while frozen.
5. WDOG_MAX=8, ext_stall held 8 cycles -> hang_err=1 after the 8th stalled cycle and stays 1 after ext_stall drops. rst_n pulse -> hang_err=0.
6. HAZ_PERF_EN defined: 3 stall cycles + 2 taken branches -> perf_stall_cycles=3, perf_flush_cnt=2. Counter preloaded to 32'hFFFFFFFF wraps to 0.
